// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state to the FSM encoding.
package imem_loader_pkg;

  localparam int LEN_BYTES = 4;
  localparam int LANES     = 4;

  typedef logic [LANES-1:0] be_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles stream bytes into little-endian words with per-lane enables.
// The merged view (stored lanes plus the incoming byte) feeds the write port directly.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_insert,
  input  logic                  i_flush,
  input  logic [1:0]            i_lane,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output be_t                   o_be
);

  logic [DATA_WIDTH-1:0] r_word;
  be_t                   r_be;
  logic [DATA_WIDTH-1:0] w_word;
  be_t                   w_be;

  // Merge the incoming byte into its lane so a flush sees the complete word.
  always_comb begin
    w_word = r_word;
    w_be   = r_be;
    if (i_insert) begin
      w_word[int'(i_lane)*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
      w_be[i_lane]                                  = 1'b1;
    end else begin
      w_word = r_word;
      w_be   = r_be;
    end
  end

  // Hold partial words; emptied on flush, on a new load or on reset.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_word <= '0;
      r_be   <= '0;
    end else if (i_insert) begin
      if (i_flush) begin
        r_word <= '0;
        r_be   <= '0;
      end else begin
        r_word <= w_word;
        r_be   <= w_be;
      end
    end
  end

  assign o_word = w_word;
  assign o_be   = w_be;

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to instruction-memory word writes; holds the core via busy.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     BYTE_WIDTH = 8,
  parameter int                     DATA_WIDTH = 32,
  parameter longint unsigned        TOTAL_DATA = 1048576,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            wr_be,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  loader_state_t         r_state;
  logic [31:0]           r_cnt;
  logic [31:0]           r_len;
  logic                  r_rx_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  be_t                   r_wr_be;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] r_csum;
`endif

  logic                  w_hs;
  logic [31:0]           w_byte32;
  logic [31:0]           w_len_next;
  logic                  w_len_ovf;
  logic                  w_last;
  logic                  w_flush;
  logic                  w_insert;
  logic                  w_clear;
  logic [DATA_WIDTH-1:0] w_word;
  be_t                   w_be;

  assign w_hs       = rx_valid & r_rx_ready;
  assign w_byte32   = 32'(rx_data);
  assign w_len_next = r_len | (w_byte32 << (5'd8 * {3'b000, r_cnt[1:0]}));
  // 33-bit sum so BASE_ADDR + len cannot wrap past the memory size check.
  assign w_len_ovf  = ({1'b0, 32'(BASE_ADDR)} + {1'b0, w_len_next}) > 33'(TOTAL_DATA);
  assign w_last     = (r_cnt == (r_len - 32'd1));
  assign w_flush    = (r_cnt[1:0] == 2'd3) | w_last;
  assign w_insert   = (r_state == ST_DATA) & w_hs;
  assign w_clear    = (r_state == ST_IDLE) & start;

  imem_word_packer #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_insert (w_insert),
    .i_flush  (w_flush),
    .i_lane   (r_cnt[1:0]),
    .i_byte   (rx_data),
    .o_word   (w_word),
    .o_be     (w_be)
  );

  // Loader FSM: length capture, data packing, optional checksum, completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 32'd0;
      r_len      <= 32'd0;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_be    <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_LEN;
            r_cnt      <= 32'd0;
            r_len      <= 32'd0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_rx_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (w_hs) begin
            r_len <= w_len_next;
            if (r_cnt[1:0] == 2'(LEN_BYTES - 1)) begin
              r_cnt <= 32'd0;
              if (w_len_ovf) begin
                r_err      <= 1'b1;
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_rx_ready <= 1'b0;
              end else if (w_len_next == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state    <= ST_CHK;
`else
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_rx_ready <= 1'b0;
`endif
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
            if (w_flush) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= BASE_ADDR + ADDR_WIDTH'({r_cnt[31:2], 2'b00});
              r_wr_data <= w_word;
              r_wr_be   <= w_be;
            end
            if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= ST_CHK;
`else
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_rx_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_hs) begin
            if (rx_data != r_csum) begin
              r_err <= 1'b1;
            end
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_rx_ready <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = r_rx_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_be    = r_wr_be;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; covers checksum loads when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit HAS_CSUM = 1'b1;
`else
  localparam bit HAS_CSUM = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_be[$];

  logic [7:0]  tb_bytes[16];
  logic [31:0] e_addr[4];
  logic [31:0] e_data[4];
  logic [3:0]  e_be[4];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_be.push_back(wr_be);
    end
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_be.delete();
    n_done = 0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwr"}, 64'(q_addr.size()), 64'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'(e_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(e_data[i]));
      check($sformatf("%s_be%0d", tag, i), 64'(q_be[i]), 64'(e_be[i]));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    if (stall) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic send_len(input logic [31:0] len, input bit stall);
    logic [31:0] t;
    for (int k = 0; k < 4; k++) begin
      t = len >> (8 * k);
      send_byte(t[7:0], stall);
    end
  endtask

  // Full load; offers an excess byte 0x77 afterwards, which must not be taken.
  task automatic run_load(input string tag, input logic [31:0] len, input int nbytes,
                          input bit stall, input bit extra_start, input bit len_err,
                          input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    send_len(len, stall);
    for (int k = 0; k < nbytes; k++) begin
      if (extra_start && k == 2) begin
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(tb_bytes[k], stall);
      x = x ^ tb_bytes[k];
    end
    if (HAS_CSUM && !len_err) send_byte(x ^ {7'd0, corrupt}, stall);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_rdy_low"}, 64'(rx_ready), 64'd0);
    @(negedge clk);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_rdy_idle"}, 64'(rx_ready), 64'd0);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_prog8();
    tb_bytes[0] = 8'h13; tb_bytes[1] = 8'h00; tb_bytes[2] = 8'h00; tb_bytes[3] = 8'h00;
    tb_bytes[4] = 8'h93; tb_bytes[5] = 8'h00; tb_bytes[6] = 8'h10; tb_bytes[7] = 8'h00;
    e_addr[0] = 32'h0; e_data[0] = 32'h0000_0013; e_be[0] = 4'b1111;
    e_addr[1] = 32'h4; e_data[1] = 32'h0010_0093; e_be[1] = 4'b1111;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_wr_en",    64'(wr_en),    64'd0);
    check("rst_wr_addr",  64'(wr_addr),  64'd0);
    check("rst_wr_data",  64'(wr_data),  64'd0);
    check("rst_wr_be",    64'(wr_be),    64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_err",      64'(err),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two full words.
    clear_log();
    set_prog8();
    run_load("len8", 32'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_writes("len8", 2);
    check("len8_ndone", 64'(n_done), 64'd1);
    check("len8_err", 64'(err), 64'd0);

    // Partial final word.
    clear_log();
    tb_bytes[0] = 8'h11; tb_bytes[1] = 8'h22; tb_bytes[2] = 8'h33;
    tb_bytes[3] = 8'h44; tb_bytes[4] = 8'h55; tb_bytes[5] = 8'h66;
    e_addr[0] = 32'h0; e_data[0] = 32'h4433_2211; e_be[0] = 4'b1111;
    e_addr[1] = 32'h4; e_data[1] = 32'h0000_6655; e_be[1] = 4'b0011;
    run_load("len6", 32'd6, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    check_writes("len6", 2);
    check("len6_err", 64'(err), 64'd0);

    // Length just past the memory size.
    clear_log();
    run_load("ovf", 32'h0010_0001, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes("ovf", 0);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_ndone", 64'(n_done), 64'd1);

    // Exactly the memory size is legal; start clears the sticky error. Abort
    // right after the length to keep the run short.
    clear_log();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_clr_err", 64'(err), 64'd0);
    send_len(32'h0010_0000, 1'b0);
    @(negedge clk); rx_valid = 1'b0;
    check("max_len_no_err", 64'(err), 64'd0);
    check("max_len_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Zero length.
    clear_log();
    run_load("len0", 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_writes("len0", 0);
    check("len0_err", 64'(err), 64'd0);

    // Reset after three data bytes discards the partial word.
    clear_log();
    set_prog8();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_len(32'd8, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(tb_bytes[k], 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    check("mid_rst_wr_en",    64'(wr_en),    64'd0);
    check("mid_rst_wr_addr",  64'(wr_addr),  64'd0);
    check("mid_rst_wr_data",  64'(wr_data),  64'd0);
    check("mid_rst_wr_be",    64'(wr_be),    64'd0);
    check("mid_rst_busy",     64'(busy),     64'd0);
    check("mid_rst_done",     64'(done),     64'd0);
    check("mid_rst_err",      64'(err),      64'd0);
    check_writes("mid_rst", 0);
    clear_log();
    run_load("after_rst", 32'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_writes("after_rst", 2);

    // Stalled stream with a stray start mid-load.
    clear_log();
    set_prog8();
    run_load("stall", 32'd8, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    check_writes("stall", 2);
    check("stall_ndone", 64'(n_done), 64'd1);
    check("stall_err", 64'(err), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    clear_log();
    tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h02; tb_bytes[2] = 8'h04; tb_bytes[3] = 8'h08;
    e_addr[0] = 32'h0; e_data[0] = 32'h0804_0201; e_be[0] = 4'b1111;
    run_load("ck_good", 32'd4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    check_writes("ck_good", 1);
    check("ck_good_err", 64'(err), 64'd0);
    clear_log();
    run_load("ck_bad", 32'd4, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    check_writes("ck_bad", 1);
    check("ck_bad_err", 64'(err), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
